// File: rtl/bitty_pkg.sv
// Shared fetch-stage types and defaults.
// Used by fetch_unit and fetch_watchdog.
package bitty_pkg;

    localparam int ADDR_WIDTH  = 16;
    localparam int INSTR_WIDTH = 16;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [2:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD,
        FETCH_ERR
    } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive WAIT cycles and flags when the limit is reached.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog
    import bitty_pkg::*;
#(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count while waiting; any cycle outside WAIT rearms the counter.
    always_comb begin
        count_d = '0;
        if (active) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires during the LIMIT-th consecutive WAIT cycle.
    assign expired = active && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and holds one fetched word.
// Optional memory timeout watchdog enabled by FETCH_TIMEOUT_EN.
module fetch_unit
    import bitty_pkg::*;
#(
    parameter int                ADDR_W         = ADDR_WIDTH,
    parameter int                DATA_W         = INSTR_WIDTH,
    parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              en_pc,
    input  logic [ADDR_W-1:0] updated_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] current_pc,
    output logic [DATA_W-1:0] instruction_from_memory,
    output logic              instr_valid,
    output logic              fetch_error
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;

`ifdef FETCH_TIMEOUT_EN
    logic err_q, err_d;
    logic wd_expired;

    fetch_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .active  (state_q == FETCH_WAIT),
        .expired (wd_expired)
    );
`endif

    // Next-state and datapath updates for the fetch handshake.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
`ifdef FETCH_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            FETCH_IDLE: begin
                if (run) begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (mem_ready) begin
                    state_d = FETCH_WAIT;
                end else if (!run) begin
                    state_d = FETCH_IDLE;
                end
            end
            FETCH_WAIT: begin
                if (mem_valid) begin
                    instr_d = mem_rdata;
                    valid_d = 1'b1;
                    state_d = FETCH_HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wd_expired) begin
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = FETCH_ERR;
                end
`endif
            end
            FETCH_HOLD: begin
                if (en_pc) begin
                    pc_d    = updated_pc;
                    valid_d = 1'b0;
                    state_d = run ? FETCH_REQ : FETCH_IDLE;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            FETCH_ERR: begin
                state_d = FETCH_ERR;
            end
`endif
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // State, PC and instruction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign mem_req                 = (state_q == FETCH_REQ);
    assign mem_addr                = pc_q;
    assign current_pc              = pc_q;
    assign instruction_from_memory = instr_q;
    assign instr_valid             = valid_q;

`ifdef FETCH_TIMEOUT_EN
    assign fetch_error = err_q;
`else
    assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Define FETCH_TIMEOUT_EN to also cover the watchdog build.
module tb_fetch_unit;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        en_pc;
    logic [15:0] updated_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic [15:0] current_pc;
    logic [15:0] instruction_from_memory;
    logic        instr_valid;
    logic        fetch_error;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    fetch_unit dut (
        .clk                     (clk),
        .reset                   (reset),
        .run                     (run),
        .en_pc                   (en_pc),
        .updated_pc              (updated_pc),
        .mem_req                 (mem_req),
        .mem_addr                (mem_addr),
        .mem_ready               (mem_ready),
        .mem_valid               (mem_valid),
        .mem_rdata               (mem_rdata),
        .current_pc              (current_pc),
        .instruction_from_memory (instruction_from_memory),
        .instr_valid             (instr_valid),
        .fetch_error             (fetch_error)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: request pending, transaction open,
    // word held, or error; updated once per rising edge.
    logic [15:0] m_pc    = 16'h0;
    logic [15:0] m_instr = 16'h0;
    bit          m_valid = 1'b0;
    bit          m_req   = 1'b0;
    bit          m_open  = 1'b0;
    bit          m_err   = 1'b0;
    int          m_wcnt  = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc    = 16'h0000;
            m_instr = 16'h0000;
            m_valid = 1'b0;
            m_req   = 1'b0;
            m_open  = 1'b0;
            m_err   = 1'b0;
            m_wcnt  = 0;
        end else if (m_err) begin
            m_req = 1'b0;
        end else if (m_open) begin
            if (mem_valid) begin
                m_instr = mem_rdata;
                m_valid = 1'b1;
                m_open  = 1'b0;
            end else begin
                m_wcnt = m_wcnt + 1;
`ifdef FETCH_TIMEOUT_EN
                if (m_wcnt == TO) begin
                    m_err   = 1'b1;
                    m_valid = 1'b0;
                    m_open  = 1'b0;
                end
`endif
            end
        end else if (m_req) begin
            if (mem_ready) begin
                m_req  = 1'b0;
                m_open = 1'b1;
                m_wcnt = 0;
            end else if (!run) begin
                m_req = 1'b0;
            end
        end else if (m_valid) begin
            if (en_pc) begin
                m_pc    = updated_pc;
                m_valid = 1'b0;
                m_req   = run;
            end
        end else if (run) begin
            m_req = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m_mem_req", 32'(mem_req), 32'(m_req));
            chk("m_mem_addr", 32'(mem_addr), 32'(m_pc));
            chk("m_current_pc", 32'(current_pc), 32'(m_pc));
            chk("m_instr", 32'(instruction_from_memory), 32'(m_instr));
            chk("m_instr_valid", 32'(instr_valid), 32'(m_valid));
            chk("m_fetch_error", 32'(fetch_error), 32'(m_err));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        run        = 1'b0;
        en_pc      = 1'b0;
        updated_pc = 16'h0;
        mem_ready  = 1'b0;
        mem_valid  = 1'b0;
        mem_rdata  = 16'hDEAD;
        tick();
        tick();
        cmp_on = 1'b1;
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_pc", 32'(current_pc), 32'h0);
        chk("rst_instr", 32'(instruction_from_memory), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_err", 32'(fetch_error), 32'h0);

        // Best-case fetch of A5A2 from PC 0.
        reset = 1'b0;
        run = 1'b1;
        mem_ready = 1'b1;
        tick();
        chk("t1_req", 32'(mem_req), 32'h1);
        chk("t1_addr", 32'(mem_addr), 32'h0);
        mem_valid = 1'b1;
        mem_rdata = 16'hA5A2;
        tick();
        chk("t1_wait_req", 32'(mem_req), 32'h0);
        chk("t1_not_yet", 32'(instr_valid), 32'h0);
        mem_ready = 1'b0;
        tick();
        chk("t1_valid", 32'(instr_valid), 32'h1);
        chk("t1_instr", 32'(instruction_from_memory), 32'hA5A2);
        chk("t1_pc", 32'(current_pc), 32'h0);
        mem_valid = 1'b0;
        tick();
        tick();
        chk("t1_held", 32'(instr_valid), 32'h1);

        // Branch to 0123; memory stalls then run drops.
        en_pc = 1'b1;
        updated_pc = 16'h0123;
        tick();
        chk("t2_req", 32'(mem_req), 32'h1);
        chk("t2_addr", 32'(mem_addr), 32'h0123);
        chk("t2_invalid", 32'(instr_valid), 32'h0);
        en_pc = 1'b0;
        repeat (4) tick();
        chk("t2_stall_req", 32'(mem_req), 32'h1);
        run = 1'b0;
        tick();
        chk("t2_withdraw", 32'(mem_req), 32'h0);
        chk("t2_keep_instr", 32'(instruction_from_memory), 32'hA5A2);
        mem_valid = 1'b1;
        mem_rdata = 16'h7777;
        tick();
        tick();
        chk("t2_idle_ignore", 32'(instr_valid), 32'h0);
        mem_valid = 1'b0;
        run = 1'b1;
        tick();
        chk("t2_restart_addr", 32'(mem_addr), 32'h0123);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        run = 1'b0;
        en_pc = 1'b1;
        updated_pc = 16'h5555;
        tick();
        tick();
        chk("t2_wait_pc", 32'(current_pc), 32'h0123);
        en_pc = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 16'h1234;
        tick();
        chk("t2_late_valid", 32'(instr_valid), 32'h1);
        chk("t2_late_instr", 32'(instruction_from_memory), 32'h1234);
        mem_valid = 1'b0;
        repeat (3) tick();
        chk("t2_hold_pc", 32'(current_pc), 32'h0123);

        // Fetch at FFFF then wrap to 0000.
        run = 1'b1;
        en_pc = 1'b1;
        updated_pc = 16'hFFFF;
        tick();
        chk("t3_addr_ffff", 32'(mem_addr), 32'hFFFF);
        en_pc = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        chk("t3_instr_ffff", 32'(instruction_from_memory), 32'hBEEF);
        mem_valid = 1'b0;
        en_pc = 1'b1;
        updated_pc = 16'h0000;
        tick();
        chk("t3_addr_0000", 32'(mem_addr), 32'h0000);
        chk("t3_req_0000", 32'(mem_req), 32'h1);
        en_pc = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 16'h0F0F;
        tick();
        chk("t3_instr_0000", 32'(instruction_from_memory), 32'h0F0F);
        mem_valid = 1'b0;

        // Reset while a transaction is open; late response ignored.
        en_pc = 1'b1;
        updated_pc = 16'h0042;
        tick();
        en_pc = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        reset = 1'b1;
        run = 1'b0;
        tick();
        reset = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 16'h9999;
        tick();
        tick();
        chk("t4_valid", 32'(instr_valid), 32'h0);
        chk("t4_instr", 32'(instruction_from_memory), 32'h0);
        chk("t4_pc", 32'(current_pc), 32'h0);
        mem_valid = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        // Data arriving in the limit cycle wins.
        run = 1'b1;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        run = 1'b0;
        repeat (TO - 1) tick();
        mem_valid = 1'b1;
        mem_rdata = 16'hABCD;
        tick();
        chk("t5_limit_err", 32'(fetch_error), 32'h0);
        chk("t5_limit_instr", 32'(instruction_from_memory), 32'hABCD);
        mem_valid = 1'b0;

        // No response: error exactly TO cycles after WAIT entry.
        run = 1'b1;
        en_pc = 1'b1;
        updated_pc = 16'h0010;
        tick();
        en_pc = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        repeat (TO - 1) tick();
        chk("t6_err_early", 32'(fetch_error), 32'h0);
        tick();
        chk("t6_err_set", 32'(fetch_error), 32'h1);
        chk("t6_err_valid", 32'(instr_valid), 32'h0);
        repeat (3) tick();
        chk("t6_err_noreq", 32'(mem_req), 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run = 1'b0;
        chk("t6_err_clear", 32'(fetch_error), 32'h0);
`else
        // Without the watchdog WAIT waits indefinitely.
        run = 1'b1;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        run = 1'b0;
        repeat (20) tick();
        chk("t6_no_err", 32'(fetch_error), 32'h0);
        chk("t6_still_wait", 32'(mem_req), 32'h0);
        mem_valid = 1'b1;
        mem_rdata = 16'hCAFE;
        tick();
        chk("t6_late_instr", 32'(instruction_from_memory), 32'hCAFE);
        mem_valid = 1'b0;
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
